// File: rtl/dmem_responder_if.sv
// Request/response bus between the CPU MEM stage (master) and the data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_signed, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_signed, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised RAM with byte lanes, fixed wait states,
// sign/zero-extended loads and misalignment/illegal-size error responses.
module dmem_responder #(
  parameter int ADDR_W      = 14,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic              r_signed;
  logic              r_err;
  logic [1:0]        r_size;
  logic [ADDR_W+1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic [31:0]       r_resp_rdata;

  logic [31:0]       r_mem [2**ADDR_W];

  logic              w_accept;
  logic              w_misaligned;
  logic              w_access;
  logic              w_do_store;
  logic [ADDR_W-1:0] w_idx;
  logic [1:0]        w_lane;
  logic [31:0]       w_word;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_rdata;
  logic [3:0]        w_wmask;
  logic [31:0]       w_wlanes;
  logic              w_unused;

  assign w_accept   = bus.req_valid && (r_state == S_IDLE);
  assign w_access   = (r_state == S_WAIT) && (r_cnt == '0);
  assign w_do_store = w_access && r_we && !r_err && !rst;
  assign w_idx      = r_addr[ADDR_W+1:2];
  assign w_lane     = r_addr[1:0];
  assign w_word     = r_mem[w_idx];
  assign w_byte     = w_word[{w_lane, 3'b000} +: 8];
  assign w_half     = r_addr[1] ? w_word[31:16] : w_word[15:0];
  assign w_unused   = &{1'b0, bus.req_addr[31:ADDR_W+2]};

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;

  // Classify the incoming request: half needs addr[0]=0, word needs addr[1:0]=0, size 3 is illegal.
  always_comb begin
    w_misaligned = 1'b0;
    case (bus.req_size)
      2'd0:    w_misaligned = 1'b0;
      2'd1:    w_misaligned = bus.req_addr[0];
      2'd2:    w_misaligned = |bus.req_addr[1:0];
      default: w_misaligned = 1'b1;
    endcase
  end

  // Load extraction/extension and store lane mask/data for the captured request.
  always_comb begin
    w_rdata  = '0;
    w_wmask  = '0;
    w_wlanes = '0;
    case (r_size)
      2'd0: begin
        w_rdata  = {{24{r_signed & w_byte[7]}}, w_byte};
        w_wmask  = 4'b0001 << w_lane;
        w_wlanes = {4{r_wdata[7:0]}};
      end
      2'd1: begin
        w_rdata  = {{16{r_signed & w_half[15]}}, w_half};
        w_wmask  = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{r_wdata[15:0]}};
      end
      default: begin
        w_rdata  = w_word;
        w_wmask  = 4'b1111;
        w_wlanes = r_wdata;
      end
    endcase
  end

  // RAM write port: only the enabled byte lanes of the addressed word change.
  always_ff @(posedge clk) begin
    if (w_do_store) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (w_wmask[k]) r_mem[w_idx][8*k +: 8] <= w_wlanes[8*k +: 8];
      end
    end
  end

  // Request FSM: capture on acceptance, count wait states, perform access, emit one-cycle response.
  // Errored requests pass through WAIT with a zero count and skip the RAM, which gives them
  // a one-cycle turnaround with the same registered response path as aligned accesses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_signed     <= 1'b0;
      r_err        <= 1'b0;
      r_size       <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we     <= bus.req_we;
            r_signed <= bus.req_signed;
            r_size   <= bus.req_size;
            r_addr   <= bus.req_addr[ADDR_W+1:0];
            r_wdata  <= bus.req_wdata;
            r_err    <= w_misaligned;
            r_cnt    <= w_misaligned ? '0 : 4'(WAIT_CYCLES);
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= r_err;
            r_resp_rdata <= (r_err || r_we) ? '0 : w_rdata;
            r_state      <= S_RESP;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized traffic
// checked against a byte-addressed memory model.
module tb_dmem_responder;
  localparam int ADDR_W      = 14;
  localparam int WAIT_CYCLES = 2;
  localparam int unsigned AMASK = (1 << (ADDR_W + 2)) - 1;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  logic [7:0] mdl [int unsigned];

  dmem_responder_if bus ();

  dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] mdl_byte(input int unsigned a);
    return mdl.exists(a) ? mdl[a] : 8'h00;
  endfunction

  function automatic logic mdl_err(input logic [31:0] addr, input logic [1:0] size);
    int unsigned nb = 1 << size;
    return (size == 2'd3) || ((addr % nb) != 0);
  endfunction

  function automatic logic [31:0] mdl_load(input logic [31:0] addr, input logic [1:0] size, input logic sgn);
    int unsigned a  = addr & AMASK;
    int unsigned nb = 1 << size;
    longint unsigned v = 0;
    for (int i = 0; i < nb; i++) v += 64'(mdl_byte(a + i)) << (8 * i);
    if (sgn && nb < 4 && v >= (64'd1 << (8 * nb - 1))) v += 64'h1_0000_0000 - (64'd1 << (8 * nb));
    return v[31:0];
  endfunction

  task automatic mdl_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata);
    int unsigned a  = addr & AMASK;
    int unsigned nb = 1 << size;
    for (int i = 0; i < nb; i++) mdl[a + i] = 8'(wdata >> (8 * i));
  endtask

  // Issue one request and return response latency (cycles after the accepting edge),
  // response data/error and whether resp_valid was still high one cycle later.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic sgn, input logic [31:0] wdata, output int lat,
                       output logic [31:0] rdata, output logic err, output logic tail);
    int n;
    @(negedge clk);
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_wdata  = wdata;
    bus.req_valid  = 1'b1;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 0;
    while (bus.resp_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
    @(negedge clk);
    tail = bus.resp_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); end
    n_cmp++; if (bus.resp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", bus.resp_rdata); end
    n_cmp++; if (bus.resp_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.resp_err); end
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_word();
    int lat; logic [31:0] rd; logic er, tl;
    issue(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, lat, rd, er, tl);
    mdl_store(32'h10, 2'd2, 32'hDEADBEEF);
    n_cmp++; if (lat !== WAIT_CYCLES + 1) begin n_bad++; $display("FAIL word_store_latency: got %0d want %0d", lat, WAIT_CYCLES + 1); end
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL word_store_err: got %b want 0", er); end
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL word_store_rdata: got %h want 0", rd); end
    n_cmp++; if (tl !== 1'b0) begin n_bad++; $display("FAIL word_store_pulse: resp_valid still %b want 0", tl); end
    issue(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, lat, rd, er, tl);
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL word_load: got %h want deadbeef", rd); end
    n_cmp++; if (lat !== WAIT_CYCLES + 1) begin n_bad++; $display("FAIL word_load_latency: got %0d want %0d", lat, WAIT_CYCLES + 1); end
  endtask

  task automatic test_byte();
    int lat; logic [31:0] rd; logic er, tl;
    issue(1'b1, 32'h11, 2'd0, 1'b0, 32'h12345680, lat, rd, er, tl);
    mdl_store(32'h11, 2'd0, 32'h12345680);
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL byte_store_err: got %b want 0", er); end
    issue(1'b0, 32'h11, 2'd0, 1'b1, 32'h0, lat, rd, er, tl);
    n_cmp++; if (rd !== 32'hFFFFFF80) begin n_bad++; $display("FAIL byte_load_signed: got %h want ffffff80", rd); end
    issue(1'b0, 32'h11, 2'd0, 1'b0, 32'h0, lat, rd, er, tl);
    n_cmp++; if (rd !== 32'h00000080) begin n_bad++; $display("FAIL byte_load_unsigned: got %h want 00000080", rd); end
    issue(1'b0, 32'h10, 2'd2, 1'b1, 32'h0, lat, rd, er, tl);
    n_cmp++; if (rd !== 32'hDEAD80EF) begin n_bad++; $display("FAIL byte_lane_word: got %h want dead80ef", rd); end
  endtask

  task automatic test_half();
    int lat; logic [31:0] rd; logic er, tl;
    issue(1'b0, 32'h12, 2'd1, 1'b1, 32'h0, lat, rd, er, tl);
    n_cmp++; if (rd !== 32'hFFFFDEAD) begin n_bad++; $display("FAIL half_load_signed: got %h want ffffdead", rd); end
    issue(1'b1, 32'h12, 2'd1, 1'b0, 32'hCAFE1234, lat, rd, er, tl);
    mdl_store(32'h12, 2'd1, 32'hCAFE1234);
    issue(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, lat, rd, er, tl);
    n_cmp++; if (rd !== 32'h123480EF) begin n_bad++; $display("FAIL half_store_word: got %h want 123480ef", rd); end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic er, tl;
    issue(1'b1, 32'h13, 2'd2, 1'b0, 32'h55555555, lat, rd, er, tl);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL misalign_latency: got %0d want 1", lat); end
    n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL misalign_err: got %b want 1", er); end
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL misalign_rdata: got %h want 0", rd); end
    n_cmp++; if (tl !== 1'b0) begin n_bad++; $display("FAIL misalign_pulse: resp_valid still %b want 0", tl); end
    issue(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, lat, rd, er, tl);
    n_cmp++; if (rd !== 32'h123480EF) begin n_bad++; $display("FAIL misalign_no_write: got %h want 123480ef", rd); end
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL err_cleared: got %b want 0", er); end
    issue(1'b0, 32'h10, 2'd3, 1'b0, 32'h0, lat, rd, er, tl);
    n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL illegal_size_err: got %b want 1", er); end
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL illegal_size_rdata: got %h want 0", rd); end
    issue(1'b0, 32'h11, 2'd1, 1'b0, 32'h0, lat, rd, er, tl);
    n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL half_misalign_err: got %b want 1", er); end
  endtask

  task automatic test_back_to_back();
    logic        t_we   [5];
    logic [31:0] t_addr [5];
    logic [1:0]  t_size [5];
    logic        t_sgn  [5];
    logic [31:0] t_wd   [5];
    logic [31:0] exp_rd, rd;
    logic        er;
    int n, low, nresp;
    t_we[0] = 1'b1; t_addr[0] = 32'h10 + (32'h1 << (ADDR_W + 2)); t_size[0] = 2'd2; t_sgn[0] = 1'b0; t_wd[0] = $urandom;
    t_we[1] = 1'b0; t_addr[1] = 32'h10; t_size[1] = 2'd2; t_sgn[1] = 1'b0; t_wd[1] = 32'h0;
    t_we[2] = 1'b1; t_addr[2] = 32'h32; t_size[2] = 2'd1; t_sgn[2] = 1'b0; t_wd[2] = $urandom | 32'h8000;
    t_we[3] = 1'b0; t_addr[3] = 32'h32; t_size[3] = 2'd1; t_sgn[3] = 1'b1; t_wd[3] = 32'h0;
    t_we[4] = 1'b0; t_addr[4] = 32'h33; t_size[4] = 2'd0; t_sgn[4] = 1'b0; t_wd[4] = 32'h0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.req_we = t_we[i]; bus.req_addr = t_addr[i]; bus.req_size = t_size[i];
      bus.req_signed = t_sgn[i]; bus.req_wdata = t_wd[i];
      exp_rd = t_we[i] ? 32'h0 : mdl_load(t_addr[i], t_size[i], t_sgn[i]);
      if (t_we[i]) mdl_store(t_addr[i], t_size[i], t_wd[i]);
      n = 0;
      while (bus.req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      @(posedge clk);
      low = 0; nresp = 0; rd = 32'hX; er = 1'bX;
      while (low < 40) begin
        @(negedge clk);
        if (bus.resp_valid === 1'b1) begin nresp++; rd = bus.resp_rdata; er = bus.resp_err; end
        if (bus.req_ready === 1'b1) break;
        low++;
      end
      n_cmp++; if (low !== WAIT_CYCLES + 2) begin n_bad++; $display("FAIL b2b_ready_low[%0d]: got %0d want %0d", i, low, WAIT_CYCLES + 2); end
      n_cmp++; if (nresp !== 1) begin n_bad++; $display("FAIL b2b_resp_count[%0d]: got %0d want 1", i, nresp); end
      n_cmp++; if (rd !== exp_rd) begin n_bad++; $display("FAIL b2b_rdata[%0d]: got %h want %h", i, rd, exp_rd); end
      n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL b2b_err[%0d]: got %b want 0", i, er); end
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic test_random();
    int lat; logic [31:0] rd; logic er, tl;
    logic we, sgn, exp_err;
    logic [1:0] size;
    logic [31:0] addr, wd, exp_rd;
    for (int i = 0; i < 40; i++) begin
      size = 2'($urandom_range(0, 3));
      addr = 32'h100 + $urandom_range(0, 63) + ($urandom_range(0, 3) << (ADDR_W + 2));
      if (size != 2'd3 && $urandom_range(0, 9) < 7) addr = addr & ~((32'h1 << size) - 1);
      we  = 1'($urandom_range(0, 1));
      sgn = 1'($urandom_range(0, 1));
      wd  = $urandom;
      exp_err = mdl_err(addr, size);
      exp_rd  = (exp_err || we) ? 32'h0 : mdl_load(addr, size, sgn);
      if (we && !exp_err) mdl_store(addr, size, wd);
      issue(we, addr, size, sgn, wd, lat, rd, er, tl);
      n_cmp++; if (er !== exp_err) begin n_bad++; $display("FAIL rand_err[%0d]: got %b want %b (addr %h size %0d)", i, er, exp_err, addr, size); end
      n_cmp++; if (rd !== exp_rd) begin n_bad++; $display("FAIL rand_rdata[%0d]: got %h want %h (addr %h size %0d we %b)", i, rd, exp_rd, addr, size, we); end
      n_cmp++; if (lat !== (exp_err ? 1 : WAIT_CYCLES + 1)) begin n_bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, exp_err ? 1 : WAIT_CYCLES + 1); end
    end
  endtask

  task automatic test_reset_mid_store();
    int lat; logic [31:0] rd; logic er, tl;
    issue(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, lat, rd, er, tl);
    n_cmp++; if (rd !== mdl_load(32'h10, 2'd2, 1'b0)) begin n_bad++; $display("FAIL pre_reset_load: got %h want %h", rd, mdl_load(32'h10, 2'd2, 1'b0)); end
    @(negedge clk);
    bus.req_we = 1'b1; bus.req_addr = 32'h20; bus.req_size = 2'd2;
    bus.req_signed = 1'b0; bus.req_wdata = 32'hAAAAAAAA; bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL mid_store_busy: got %b want 1", bus.busy); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_async_ready: got %b want 1", bus.req_ready); end
    n_cmp++; if (bus.resp_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_async_rdata: got %h want 0", bus.resp_rdata); end
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_async_valid: got %b want 0", bus.resp_valid); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b want 1", bus.req_ready); end
    issue(1'b0, 32'h20, 2'd2, 1'b0, 32'h0, lat, rd, er, tl);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL discarded_store: got %h want 0", rd); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_size   = '0;
    bus.req_signed = 1'b0;
    bus.req_wdata  = '0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_mid_store();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
